// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment display driver and its capture monitor:
// glyph table (active-low gfedcba), capture FSM states and anode-select helpers.
package sseg_pkg;

  localparam int NDIG = 4;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_e;

  // Upper anodes off and exactly one of the four digit anodes driven low.
  function automatic logic sel_legal(input logic [7:0] an);
    return (an[7:4] == 4'hF) && ($countones(~an[3:0]) == 1);
  endfunction

  function automatic logic [1:0] sel_index(input logic [3:0] an_lo);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!an_lo[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sseg_glyph_decode.sv
// Combinational reverse lookup of an active-low gfedcba pattern to a hex nibble.
module sseg_glyph_decode
  import sseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic [3:0] nibble
);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hit    = 1'b0;
    nibble = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPH[i]) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/sseg_capture.sv
// Receive-side monitor for the multiplexed seven-segment bus: settles each digit, rebuilds the word.
// Optional decimal-point capture is enabled by defining SSEG_CAPTURE_DP_EN.
module sseg_capture
  import sseg_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [7:0]  sseg_in,
  input  logic [7:0]  an_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        frame_done,
  output logic        data_changed,
  output logic        decode_err,
  output logic [3:0]  dp_out
);

  logic [7:0]      sseg_q, an_q, an_prev_q;
  logic [7:0]      cnt_q, cnt_d;
  state_e          state_q, state_d;
  logic [15:0]     shadow_q, shadow_d;
  logic [NDIG-1:0] seen_q, seen_d;
  logic [15:0]     data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_q, frame_d;
  logic            changed_q, changed_d;
  logic            err_q, err_d;

  logic            an_changed, an_legal, an_blank, capture;
  logic [1:0]      dig_k;
  logic            glyph_hit;
  logic [3:0]      glyph_nib;

  sseg_glyph_decode u_decode (
    .seg    (sseg_q[6:0]),
    .hit    (glyph_hit),
    .nibble (glyph_nib)
  );

  assign an_changed = (an_q != an_prev_q);
  assign an_legal   = sel_legal(an_q);
  assign an_blank   = (an_q == 8'hFF);
  assign dig_k      = sel_index(an_q[3:0]);

`ifdef SSEG_CAPTURE_DP_EN
  logic [NDIG-1:0] dp_shadow_q, dp_shadow_d;
  logic [NDIG-1:0] dp_q, dp_d;
`else
  logic unused_dp;
  assign unused_dp = sseg_q[7];
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = an_changed ? 8'd0 : ((cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1);
    shadow_d  = shadow_q;
    seen_d    = seen_q;
    data_d    = data_q;
    valid_d   = valid_q;
    frame_d   = 1'b0;
    changed_d = 1'b0;
    err_d     = err_q;
    capture   = 1'b0;
`ifdef SSEG_CAPTURE_DP_EN
    dp_shadow_d = dp_shadow_q;
    dp_d        = dp_q;
`endif

    if (!an_legal && !an_blank) err_d = 1'b1;

    unique case (state_q)
      ST_IDLE:   if (an_legal) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (an_changed) begin
          state_d = an_legal ? ST_SETTLE : ST_IDLE;
        end else if (cnt_q == 8'(SETTLE - 1)) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD:   if (an_changed) state_d = an_legal ? ST_SETTLE : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (capture) begin
      if (glyph_hit) begin
        shadow_d[{dig_k, 2'b00} +: 4] = glyph_nib;
        seen_d[dig_k]                 = 1'b1;
`ifdef SSEG_CAPTURE_DP_EN
        dp_shadow_d[dig_k]            = ~sseg_q[7];
`endif
      end else begin
        err_d = 1'b1;
      end

      // The capture that fills the last digit publishes the frame on the same edge.
      if (seen_d == '1) begin
        data_d  = shadow_d;
        valid_d = 1'b1;
        frame_d = 1'b1;
        seen_d  = '0;
`ifdef SSEG_CAPTURE_DP_EN
        dp_d      = dp_shadow_d;
        changed_d = !valid_q || ({dp_d, data_d} != {dp_q, data_q});
`else
        changed_d = !valid_q || (data_d != data_q);
`endif
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clear) begin
      sseg_q    <= 8'hFF;
      an_q      <= 8'hFF;
      an_prev_q <= 8'hFF;
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      shadow_q  <= '0;
      seen_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      frame_q   <= 1'b0;
      changed_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef SSEG_CAPTURE_DP_EN
      dp_shadow_q <= '0;
      dp_q        <= '0;
`endif
    end else begin
      sseg_q    <= sseg_in;
      an_q      <= an_in;
      an_prev_q <= an_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      seen_q    <= seen_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      frame_q   <= frame_d;
      changed_q <= changed_d;
      err_q     <= err_d;
`ifdef SSEG_CAPTURE_DP_EN
      dp_shadow_q <= dp_shadow_d;
      dp_q        <= dp_d;
`endif
    end
  end

  assign data_out     = data_q;
  assign data_valid   = valid_q;
  assign frame_done   = frame_q;
  assign data_changed = changed_q;
  assign decode_err   = err_q;
`ifdef SSEG_CAPTURE_DP_EN
  assign dp_out       = dp_q;
`else
  assign dp_out       = '0;
`endif

endmodule

// File: tb/tb_sseg_capture.sv
// Bench for sseg_capture: directed display scenarios plus random dwells against a dwell-level model.
module tb_sseg_capture;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        clear;
  logic [7:0]  sseg_in, an_in;
  logic [15:0] data_out;
  logic        data_valid, frame_done, data_changed, decode_err;
  logic [3:0]  dp_out;

  always #5 clk = ~clk;

  sseg_capture #(.SETTLE(SETTLE)) dut (
    .clk          (clk),
    .clear        (clear),
    .sseg_in      (sseg_in),
    .an_in        (an_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .frame_done   (frame_done),
    .data_changed (data_changed),
    .decode_err   (decode_err),
    .dp_out       (dp_out)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [15:0] d;
    logic        ch;
    logic [3:0]  dp;
  } frame_t;

  frame_t obs_q[$];
  frame_t exp_q[$];

  always @(negedge clk) begin
    frame_t fr;
    if (!clear && frame_done) begin
      fr.c  = cyc;
      fr.d  = data_out;
      fr.ch = data_changed;
      fr.dp = dp_out;
      obs_q.push_back(fr);
    end
  end

  // Reference glyphs, active-low gfedcba.
  logic [6:0] glyphs [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Dwell-level model of what the display should have produced.
  logic [3:0]  m_sh [4];
  logic        m_dp [4];
  logic [3:0]  m_seen;
  logic [15:0] m_prev;
  logic [3:0]  m_prev_dp;
  logic        m_valid, m_err;
  logic [7:0]  prev_an;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_sh[i] = '0;
      m_dp[i] = 1'b0;
    end
    m_seen = '0; m_prev = '0; m_prev_dp = '0;
    m_valid = 1'b0; m_err = 1'b0; prev_an = 8'hFF;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] an_sel(input int k);
    logic [7:0] a;
    a = 8'hFF;
    a[k] = 1'b0;
    return a;
  endfunction

  // Show one anode pattern with one segment pattern for len cycles and predict the outcome.
  task automatic dwell(input logic [7:0] an, input logic [7:0] seg, input int len);
    int zeros, k, start;
    logic found;
    logic [3:0] nib;
    frame_t fr;
    @(negedge clk);
    an_in = an; sseg_in = seg; start = cyc; prev_an = an;
    zeros = 0; k = 0;
    for (int i = 0; i < 4; i++) if (!an[i]) begin zeros++; k = i; end
    if (!(an[7:4] == 4'hF && zeros == 1)) begin
      if (an != 8'hFF) m_err = 1'b1;
    end else if (len >= SETTLE + 1) begin
      found = 1'b0; nib = '0;
      for (int g = 0; g < 16; g++) if (glyphs[g] == seg[6:0]) begin found = 1'b1; nib = 4'(g); end
      if (!found) m_err = 1'b1;
      else begin
        m_sh[k] = nib;
        m_seen[k] = 1'b1;
`ifdef SSEG_CAPTURE_DP_EN
        m_dp[k] = ~seg[7];
`endif
        if (m_seen == 4'hF) begin
          fr.c  = start + SETTLE + 2;
          fr.d  = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
          fr.dp = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
          fr.ch = !m_valid || ({fr.dp, fr.d} != {m_prev_dp, m_prev});
          exp_q.push_back(fr);
          m_prev = fr.d; m_prev_dp = fr.dp; m_valid = 1'b1; m_seen = '0;
        end
      end
    end
    repeat (len - 1) @(negedge clk);
  endtask

  task automatic send_digit(input logic [15:0] w, input int k, input int len);
    logic [3:0] n;
    n = w[4*k +: 4];
    dwell(an_sel(k), {1'b1, glyphs[n]}, len);
  endtask

  task automatic send_word(input logic [15:0] w, input int len);
    for (int k = 0; k < 4; k++) send_digit(w, k, len);
    dwell(8'hFF, 8'hFF, SETTLE + 4);
  endtask

  task automatic check_frames(input string tag);
    int n;
    check({tag, ".count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, ".cycle"},   obs_q[i].c,  exp_q[i].c);
      check({tag, ".data"},    obs_q[i].d,  exp_q[i].d);
      check({tag, ".changed"}, obs_q[i].ch, exp_q[i].ch);
      check({tag, ".dp"},      obs_q[i].dp, exp_q[i].dp);
    end
    obs_q.delete();
    exp_q.delete();
    check({tag, ".data_out"},   data_out,   m_prev);
    check({tag, ".data_valid"}, data_valid, m_valid);
    check({tag, ".decode_err"}, decode_err, m_err);
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk);
    an_in = 8'hFF; sseg_in = 8'hFF; clear = 1'b1;
    repeat (2) @(negedge clk);
    check({tag, ".data_out"},     data_out,     16'h0);
    check({tag, ".data_valid"},   data_valid,   1'b0);
    check({tag, ".frame_done"},   frame_done,   1'b0);
    check({tag, ".data_changed"}, data_changed, 1'b0);
    check({tag, ".decode_err"},   decode_err,   1'b0);
    check({tag, ".dp_out"},       dp_out,       4'h0);
    clear = 1'b0;
    model_reset();
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] an, seg;
    int r;
    clear = 1'b1; an_in = 8'hFF; sseg_in = 8'hFF;
    model_reset();
    do_clear("reset");

    send_word(16'h8320, 16);
    check_frames("w8320");
    send_word(16'hABCD, 16);
    check_frames("wABCD");
    send_word(16'hABCD, 16);
    check_frames("wABCD_rep");

    // One-short dwell on digit 1 leaves the frame incomplete; a full dwell completes it.
    send_digit(16'h5E7C, 0, 16);
    send_digit(16'h5E7C, 2, 16);
    send_digit(16'h5E7C, 3, 16);
    send_digit(16'h5E7C, 1, SETTLE);
    dwell(8'hFF, 8'hFF, SETTLE + 4);
    check_frames("short_dwell");
    send_digit(16'h5E7C, 1, SETTLE + 1);
    dwell(8'hFF, 8'hFF, SETTLE + 4);
    check_frames("exact_dwell");

    // Clear after three captured digits discards the partial frame.
    send_digit(16'h1234, 0, 16);
    send_digit(16'h1234, 1, 16);
    send_digit(16'h1234, 2, 16);
    dwell(8'hFF, 8'hFF, 4);
    do_clear("mid_clear");
    send_word(16'h8888, 16);
    check_frames("w8888");

    dwell(8'hFF, 8'hFF, 10);
    check_frames("blank_ok");
    dwell(8'hF5, 8'h40, 8);
    dwell(8'hFF, 8'hFF, 4);
    check_frames("two_hot");

    do_clear("clear2");
    send_digit(16'h4321, 0, 16);
    send_digit(16'h4321, 1, 16);
    dwell(an_sel(2), 8'hFF, 16);
    send_digit(16'h4321, 3, 16);
    dwell(8'hFF, 8'hFF, SETTLE + 4);
    check_frames("bad_glyph");
    send_digit(16'h4321, 2, 16);
    dwell(8'hFF, 8'hFF, SETTLE + 4);
    check_frames("glyph_fixed");

    do_clear("clear3");
    for (int i = 0; i < 300; i++) begin
      do begin
        r = $urandom_range(0, 99);
        if (r < 85)      an = an_sel($urandom_range(0, 3));
        else if (r < 93) an = 8'hFF;
        else             an = 8'($urandom);
      end while (an == prev_an);
      if ($urandom_range(0, 9) != 0) seg = {1'($urandom), glyphs[$urandom_range(0, 15)]};
      else                           seg = 8'($urandom);
      dwell(an, seg, $urandom_range(1, 2 * SETTLE + 2));
      if (i % 50 == 49) begin
        if (prev_an != 8'hFF) dwell(8'hFF, 8'hFF, SETTLE + 4);
        check_frames("random");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
